// File: rtl/l2_cache_ctrl.sv
// l2_cache_ctrl
// Direct-mapped, write-back, write-allocate L2 cache controller sitting
// between an L1 (line requests) and a memory (line fills / victim writes).
//
// Ports
//   clk, rstn                  clock (rising edge), synchronous active-low reset
//   read_L1_L2, write_L1_L2    L1 line read / line write request, held until ready
//   tag_L1_L2, index_L1_L2     request address (tag / line index)
//   write_data_L1_L2           full line written by L1
//   ready_L2_L1                one-cycle completion pulse to L1
//   read_data_L2_L1            returned line, valid while ready_L2_L1=1 (0 for writes)
//   read_L2_MEM, write_L2_MEM  memory fill / victim write-back requests
//   tag_L2_MEM                 fill tag (request tag)
//   write_tag_L2_MEM           victim tag for write-back
//   index_L2_MEM               line index for both memory operations
//   write_data_L2_MEM          victim line
//   ready_MEM_L2               memory completion pulse
//   read_data_MEM_L2           fill line
//   miss_cnt, wb_cnt           saturating miss / write-back counters
module l2_cache_ctrl #(
  parameter int TNUM   = 22,
  parameter int INUM   = 26 - TNUM,
  parameter int LINE_W = 512,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              read_L1_L2,
  input  logic              write_L1_L2,
  input  logic [TNUM-1:0]   tag_L1_L2,
  input  logic [INUM-1:0]   index_L1_L2,
  input  logic [LINE_W-1:0] write_data_L1_L2,
  output logic              ready_L2_L1,
  output logic [LINE_W-1:0] read_data_L2_L1,
  output logic              read_L2_MEM,
  output logic              write_L2_MEM,
  output logic [TNUM-1:0]   tag_L2_MEM,
  output logic [TNUM-1:0]   write_tag_L2_MEM,
  output logic [INUM-1:0]   index_L2_MEM,
  output logic [LINE_W-1:0] write_data_L2_MEM,
  input  logic              ready_MEM_L2,
  input  logic [LINE_W-1:0] read_data_MEM_L2,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt
);

  localparam int LINES = 1 << INUM;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    RESPOND
  } state_t;

  state_t state_q, state_d;

  // Line state: valid/dirty need reset, tag/data arrays do not.
  logic [LINES-1:0]  valid_q, dirty_q;
  logic [TNUM-1:0]   tag_mem  [LINES];
  logic [LINE_W-1:0] data_mem [LINES];

  // Latched request; L1 inputs are not looked at again after acceptance.
  logic [TNUM-1:0]   req_tag_q;
  logic [INUM-1:0]   req_idx_q;
  logic              req_wr_q;
  logic [LINE_W-1:0] req_data_q;
  // Registered read of the data array, taken at acceptance. It is both the
  // hit data and the victim line for a write-back.
  logic [LINE_W-1:0] line_q;

  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  miss_q, wb_q;

  logic              accept;
  logic              line_we;
  logic [LINE_W-1:0] line_wdata;
  logic              line_dirty;
  logic              clr_dirty;
  logic              miss_inc, wb_inc;

  logic [TNUM-1:0]   victim_tag;
  logic              hit, victim_dirty;
  logic [LINES-1:0]  line_sel;

  // One-hot select of the line addressed by the latched index.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_sel
    assign line_sel[gi] = (req_idx_q == INUM'(gi));
  end

  assign victim_tag   = tag_mem[req_idx_q];
  assign hit          = valid_q[req_idx_q] && (victim_tag == req_tag_q);
  assign victim_dirty = valid_q[req_idx_q] && dirty_q[req_idx_q];

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    line_we    = 1'b0;
    line_wdata = req_data_q;
    line_dirty = 1'b0;
    clr_dirty  = 1'b0;
    rd_req_d   = rd_req_q;
    wr_req_d   = wr_req_q;
    rdata_d    = rdata_q;
    miss_inc   = 1'b0;
    wb_inc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (read_L1_L2 || write_L1_L2) begin
          accept  = 1'b1;
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        if (hit) begin
          if (req_wr_q) begin
            line_we    = 1'b1;
            line_dirty = 1'b1;
            rdata_d    = '0;
          end else begin
            rdata_d = line_q;
          end
          state_d = RESPOND;
        end else begin
          miss_inc = 1'b1;
          if (victim_dirty) begin
            wb_inc   = 1'b1;
            wr_req_d = 1'b1;
            state_d  = WRITEBACK;
          end else if (req_wr_q) begin
            // Full-line write miss: install directly, nothing to fetch.
            line_we    = 1'b1;
            line_dirty = 1'b1;
            rdata_d    = '0;
            state_d    = RESPOND;
          end else begin
            rd_req_d = 1'b1;
            state_d  = ALLOCATE;
          end
        end
      end

      WRITEBACK: begin
        if (wr_req_q && ready_MEM_L2) begin
          wr_req_d  = 1'b0;
          clr_dirty = 1'b1;
          if (req_wr_q) begin
            line_we    = 1'b1;
            line_dirty = 1'b1;
            rdata_d    = '0;
            state_d    = RESPOND;
          end else begin
            // rd_req stays low for the first ALLOCATE cycle so the memory
            // sees an idle cycle between the write-back and the fill.
            state_d = ALLOCATE;
          end
        end
      end

      ALLOCATE: begin
        if (!rd_req_q) begin
          rd_req_d = 1'b1;
        end else if (ready_MEM_L2) begin
          rd_req_d   = 1'b0;
          line_we    = 1'b1;
          line_wdata = read_data_MEM_L2;
          line_dirty = 1'b0;
          rdata_d    = read_data_MEM_L2;
          state_d    = RESPOND;
        end
      end

      RESPOND: begin
        rdata_d = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      rdata_q  <= '0;
      miss_q   <= '0;
      wb_q     <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
    end else begin
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      rdata_q  <= rdata_d;
      if (miss_inc && (miss_q != CNT_MAX)) begin
        miss_q <= miss_q + CNT_ONE;
      end
      if (wb_inc && (wb_q != CNT_MAX)) begin
        wb_q <= wb_q + CNT_ONE;
      end
      // A line install takes priority over the write-back dirty clear; the
      // write-after-write-back case re-marks the line dirty in the same edge.
      if (line_we) begin
        valid_q <= valid_q | line_sel;
        dirty_q <= line_dirty ? (dirty_q | line_sel) : (dirty_q & ~line_sel);
      end else if (clr_dirty) begin
        dirty_q <= dirty_q & ~line_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_tag_q  <= tag_L1_L2;
      req_idx_q  <= index_L1_L2;
      req_wr_q   <= write_L1_L2;
      req_data_q <= write_data_L1_L2;
    end
  end

  // Tag and data arrays; data read is registered at acceptance.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_mem[req_idx_q] <= line_wdata;
      tag_mem[req_idx_q]  <= req_tag_q;
    end
    if (accept) begin
      line_q <= data_mem[index_L1_L2];
    end
  end

  assign ready_L2_L1       = (state_q == RESPOND);
  assign read_data_L2_L1   = rdata_q;
  assign read_L2_MEM       = rd_req_q;
  assign write_L2_MEM      = wr_req_q;
  assign tag_L2_MEM        = req_tag_q;
  assign write_tag_L2_MEM  = victim_tag;
  assign index_L2_MEM      = req_idx_q;
  assign write_data_L2_MEM = line_q;
  assign miss_cnt          = miss_q;
  assign wb_cnt            = wb_q;

endmodule
